// File: rtl/cube_pkg.sv
// Shared encodings for the 2x2x2 cube state engine: face/turn codes, colours,
// the solved facelet vector and the scramble LFSR step.
package cube_pkg;

    typedef enum logic [1:0] {
        FACE_U = 2'd0,
        FACE_R = 2'd1,
        FACE_F = 2'd2,
        FACE_X = 2'd3
    } face_e;

    typedef enum logic [1:0] {
        TURN_NONE = 2'd0,
        TURN_CW   = 2'd1,
        TURN_HALF = 2'd2,
        TURN_CCW  = 2'd3
    } turn_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_TURN     = 2'd1,
        ST_SCRAMBLE = 2'd2
    } state_e;

    // Colours are {blue, green, red}
    localparam logic [2:0] COL_U = 3'b111;
    localparam logic [2:0] COL_L = 3'b001;
    localparam logic [2:0] COL_F = 3'b010;
    localparam logic [2:0] COL_R = 3'b101;
    localparam logic [2:0] COL_B = 3'b100;
    localparam logic [2:0] COL_D = 3'b011;

    // Facelet 23 is the MSB group; facelet 0 the LSB group
    localparam logic [71:0] SOLVED = {
        {4{COL_D}},
        {2{COL_B}}, {2{COL_R}}, {2{COL_F}}, {2{COL_L}},
        {2{COL_B}}, {2{COL_R}}, {2{COL_F}}, {2{COL_L}},
        {4{COL_U}}
    };

    // x^16+x^14+x^13+x^11+1, Fibonacci, shifting right
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/cube_quarter_turn.sv
// One clockwise quarter turn of face U, R or F applied to a 24-facelet state.
// The reserved face code passes the state through unchanged.
module cube_quarter_turn
    import cube_pkg::*;
(
    input  logic [1:0]  face,
    input  logic [71:0] state_in,
    output logic [71:0] state_out
);

    logic [2:0] f [24];
    logic [2:0] n [24];

    always_comb begin
        for (int unsigned i = 0; i < 24; i++) begin
            f[i] = state_in[3*i +: 3];
        end
        n = f;
        case (face_e'(face))
            FACE_U: begin
                n[1]  = f[0];  n[3]  = f[1];  n[2]  = f[3];  n[0]  = f[2];
                n[4]  = f[6];  n[5]  = f[7];  n[6]  = f[8];  n[7]  = f[9];
                n[8]  = f[10]; n[9]  = f[11]; n[10] = f[4];  n[11] = f[5];
            end
            FACE_R: begin
                n[9]  = f[8];  n[17] = f[9];  n[16] = f[17]; n[8]  = f[16];
                n[3]  = f[15]; n[1]  = f[7];  n[10] = f[3];  n[18] = f[1];
                n[23] = f[10]; n[21] = f[18]; n[7]  = f[21]; n[15] = f[23];
            end
            FACE_F: begin
                n[7]  = f[6];  n[15] = f[7];  n[14] = f[15]; n[6]  = f[14];
                n[8]  = f[2];  n[16] = f[3];  n[21] = f[8];  n[20] = f[16];
                n[13] = f[21]; n[5]  = f[20]; n[2]  = f[13]; n[3]  = f[5];
            end
            default: ;
        endcase
        state_out = '0;
        for (int unsigned i = 0; i < 24; i++) begin
            state_out[3*i +: 3] = n[i];
        end
    end

endmodule

// File: rtl/cube_state_engine.sv
// Cube facelet state owner: applies handshaked face turns and LFSR scrambles one
// quarter turn per clock, and commits the working state to dat on frame_tick.
module cube_state_engine
    import cube_pkg::*;
#(
    parameter int unsigned SCRAMBLE_LEN = 20,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_face,
    input  logic [1:0]  cmd_turn,
    input  logic        scramble,
    output logic [71:0] dat,
    output logic        solved,
    output logic        busy,
    output logic [15:0] move_count
);

    state_e      fsm_q, fsm_d;
    logic [71:0] work_q, work_d;
    logic [71:0] dat_q;
    logic [1:0]  face_q, face_d;
    logic [1:0]  rem_q, rem_d;
    logic [7:0]  scr_cnt_q, scr_cnt_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] mc_q, mc_d;
    logic        solved_q;

    logic [1:0]  turn_face;
    logic [71:0] turned;

    // Scramble face is lfsr[1:0] mod 3, so code 3 folds onto U
    assign turn_face = (fsm_q == ST_SCRAMBLE)
                     ? ((lfsr_q[1:0] == 2'd3) ? FACE_U : lfsr_q[1:0])
                     : face_q;

    cube_quarter_turn u_quarter_turn (
        .face      (turn_face),
        .state_in  (work_q),
        .state_out (turned)
    );

    always_comb begin
        fsm_d     = fsm_q;
        work_d    = work_q;
        face_d    = face_q;
        rem_d     = rem_q;
        scr_cnt_d = scr_cnt_q;
        lfsr_d    = lfsr_q;
        mc_d      = mc_q;
        case (fsm_q)
            ST_IDLE: begin
                if (scramble) begin
                    fsm_d     = ST_SCRAMBLE;
                    scr_cnt_d = SCRAMBLE_LEN[7:0];
                    mc_d      = '0;
                end else if (cmd_valid && (turn_e'(cmd_turn) != TURN_NONE)
                             && (face_e'(cmd_face) != FACE_X)) begin
                    fsm_d  = ST_TURN;
                    face_d = cmd_face;
                    rem_d  = cmd_turn;
                    mc_d   = mc_q + 16'd1;
                end
            end
            ST_TURN: begin
                work_d = turned;
                rem_d  = rem_q - 2'd1;
                if (rem_q == 2'd1) begin
                    fsm_d = ST_IDLE;
                end
            end
            ST_SCRAMBLE: begin
                work_d    = turned;
                lfsr_d    = lfsr_next(lfsr_q);
                scr_cnt_d = scr_cnt_q - 8'd1;
                if (scr_cnt_q == 8'd1) begin
                    fsm_d = ST_IDLE;
                end
            end
            default: fsm_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= ST_IDLE;
            work_q    <= SOLVED;
            dat_q     <= SOLVED;
            face_q    <= '0;
            rem_q     <= '0;
            scr_cnt_q <= '0;
            lfsr_q    <= LFSR_SEED;
            mc_q      <= '0;
            solved_q  <= 1'b1;
        end else begin
            fsm_q     <= fsm_d;
            work_q    <= work_d;
            face_q    <= face_d;
            rem_q     <= rem_d;
            scr_cnt_q <= scr_cnt_d;
            lfsr_q    <= lfsr_d;
            mc_q      <= mc_d;
            solved_q  <= (work_d == SOLVED);
            // Captures the pre-edge working state, so a coincident turn is not shown yet
            if (frame_tick) begin
                dat_q <= work_q;
            end
        end
    end

    assign busy       = (fsm_q != ST_IDLE);
    assign cmd_ready  = ~busy & ~rst;
    assign dat        = dat_q;
    assign solved     = solved_q;
    assign move_count = mc_q;

endmodule

// File: tb/tb_cube_state_engine.sv
// Directed bench for cube_state_engine with hand-derived facelet vectors.
module tb_cube_state_engine;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_face;
    logic [1:0]  cmd_turn;
    logic        scramble;
    logic [71:0] dat;
    logic        solved;
    logic        busy;
    logic [15:0] move_count;

    int n_tests = 0;
    int n_fail  = 0;

    cube_state_engine #(
        .SCRAMBLE_LEN (20),
        .LFSR_SEED    (16'hACE1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_face   (cmd_face),
        .cmd_turn   (cmd_turn),
        .scramble   (scramble),
        .dat        (dat),
        .solved     (solved),
        .busy       (busy),
        .move_count (move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [71:0] put(input logic [71:0] v, input int unsigned k,
                                        input logic [2:0] c);
        logic [71:0] r;
        r = v;
        r[3*k +: 3] = c;
        return r;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    // Issue one command then count busy cycles and busy cycles with cmd_ready high
    task automatic do_move(input logic [1:0] f, input logic [1:0] t,
                           output int cycles, output int ready_hi);
        cmd_valid = 1'b1;
        cmd_face  = f;
        cmd_turn  = t;
        step();
        cmd_valid = 1'b0;
        cycles   = 0;
        ready_hi = 0;
        while (busy && cycles < 300) begin
            cycles++;
            if (cmd_ready) ready_hi++;
            step();
        end
    endtask

    logic [71:0] solved_v, exp_u, exp_r, scr1;
    int cyc, rdy, n;

    initial begin
        // Solved vector assembled facelet by facelet
        solved_v = '0;
        for (int k = 0; k < 4; k++)  solved_v = put(solved_v, k, 3'b111);
        for (int k = 20; k < 24; k++) solved_v = put(solved_v, k, 3'b011);
        for (int r = 0; r < 2; r++) begin
            solved_v = put(solved_v, 4 + 8*r,  3'b001);
            solved_v = put(solved_v, 5 + 8*r,  3'b001);
            solved_v = put(solved_v, 6 + 8*r,  3'b010);
            solved_v = put(solved_v, 7 + 8*r,  3'b010);
            solved_v = put(solved_v, 8 + 8*r,  3'b101);
            solved_v = put(solved_v, 9 + 8*r,  3'b101);
            solved_v = put(solved_v, 10 + 8*r, 3'b100);
            solved_v = put(solved_v, 11 + 8*r, 3'b100);
        end
        exp_u = solved_v;
        exp_u = put(exp_u, 4, 3'b010);  exp_u = put(exp_u, 5, 3'b010);
        exp_u = put(exp_u, 6, 3'b101);  exp_u = put(exp_u, 7, 3'b101);
        exp_u = put(exp_u, 8, 3'b100);  exp_u = put(exp_u, 9, 3'b100);
        exp_u = put(exp_u, 10, 3'b001); exp_u = put(exp_u, 11, 3'b001);
        exp_r = solved_v;
        exp_r = put(exp_r, 1, 3'b010);  exp_r = put(exp_r, 3, 3'b010);
        exp_r = put(exp_r, 7, 3'b011);  exp_r = put(exp_r, 15, 3'b011);
        exp_r = put(exp_r, 21, 3'b100); exp_r = put(exp_r, 23, 3'b100);
        exp_r = put(exp_r, 10, 3'b111); exp_r = put(exp_r, 18, 3'b111);

        rst = 1'b1; frame_tick = 1'b0; cmd_valid = 1'b0;
        cmd_face = 2'd0; cmd_turn = 2'd0; scramble = 1'b0;
        step();
        step();
        check("ready_in_rst", cmd_ready, 1'b0);
        rst = 1'b0;
        step();
        check("rst_dat", dat, solved_v);
        check("rst_solved", solved, 1'b1);
        check("rst_count", move_count, 16'd0);
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        frame();
        check("rst_tick_dat", dat, solved_v);

        // Null commands are accepted without effect
        cmd_valid = 1'b1; cmd_face = 2'd0; cmd_turn = 2'd0;
        step();
        check("null_turn_busy", busy, 1'b0);
        cmd_face = 2'd3; cmd_turn = 2'd1;
        step();
        cmd_valid = 1'b0;
        check("null_face_busy", busy, 1'b0);
        check("null_count", move_count, 16'd0);
        check("null_solved", solved, 1'b1);

        // U CW with a frame tick landing on the turn edge
        cmd_valid = 1'b1; cmd_face = 2'd0; cmd_turn = 2'd1;
        step();
        cmd_valid = 1'b0;
        check("u_busy", busy, 1'b1);
        check("u_ready", cmd_ready, 1'b0);
        check("u_pre_solved", solved, 1'b1);
        frame();
        check("u_tick_pre_turn", dat, solved_v);
        check("u_solved", solved, 1'b0);
        check("u_done", busy, 1'b0);
        check("u_count", move_count, 16'd1);
        step();
        step();
        check("u_no_tick_hold", dat, solved_v);
        frame();
        check("u_dat", dat, exp_u);

        // R CW then R CCW restores solved
        do_reset();
        do_move(2'd1, 2'd1, cyc, rdy);
        check("r_cycles", cyc, 1);
        frame();
        check("r_dat", dat, exp_r);
        check("r_solved", solved, 1'b0);
        do_move(2'd1, 2'd3, cyc, rdy);
        check("rccw_cycles", cyc, 3);
        check("rccw_ready_busy", rdy, 0);
        check("rccw_solved", solved, 1'b1);
        check("rccw_count", move_count, 16'd2);
        check("rccw_no_tick", dat, exp_r);
        frame();
        check("rccw_dat", dat, solved_v);

        // F half twice with cmd_valid held continuously
        do_reset();
        cmd_valid = 1'b1; cmd_face = 2'd2; cmd_turn = 2'd2;
        step();
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check("f2_cycles", n, 2);
        check("f2_ready_again", cmd_ready, 1'b1);
        check("f2_half_solved", solved, 1'b0);
        step();
        cmd_valid = 1'b0;
        check("f2_second_busy", busy, 1'b1);
        n = 0;
        while (busy && n < 50) begin
            n++;
            step();
        end
        check("f2_second_cycles", n, 2);
        check("f2_solved", solved, 1'b1);
        check("f2_count", move_count, 16'd2);

        // Scramble beats a simultaneous command; a re-pulse while busy is ignored
        scramble = 1'b1; cmd_valid = 1'b1; cmd_face = 2'd0; cmd_turn = 2'd1;
        step();
        scramble = 1'b0; cmd_valid = 1'b0;
        check("scr_count_clear", move_count, 16'd0);
        n = 0;
        while (busy && n < 300) begin
            n++;
            scramble = (n == 5);
            step();
        end
        scramble = 1'b0;
        check("scr_cycles", n, 20);
        check("scr_count", move_count, 16'd0);
        check("scr_solved", solved, 1'b0);
        frame();
        scr1 = dat;
        check("scr_dat_changed", (dat == solved_v), 1'b0);

        // Same seed after reset must give the same scramble
        do_reset();
        scramble = 1'b1;
        step();
        scramble = 1'b0;
        n = 0;
        while (busy && n < 300) begin
            n++;
            step();
        end
        check("scr2_cycles", n, 20);
        frame();
        check("scr2_repeat", dat, scr1);

        // Reset in the middle of a scramble
        scramble = 1'b1;
        step();
        scramble = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
        check("mid_rst_ready", cmd_ready, 1'b0);
        step();
        check("mid_rst_solved", solved, 1'b1);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_dat", dat, solved_v);
        check("mid_rst_count", move_count, 16'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", cmd_ready, 1'b1);
        step();
        frame();
        check("post_rst_tick", dat, solved_v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
